mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative RV64M multiply/divide unit. One operation is in flight at a
//   time. Multiplies use shift-add on operand magnitudes. Divides use
//   restoring division on magnitudes, producing one quotient bit per cycle.
//   Signs are applied to the final value. The RISC-V boundary cases
//   (divide by zero, signed overflow) are resolved when the operation is
//   accepted, so the iteration datapath never has to produce them.
//
// Ports
//   clk      in   1     rising-edge clock
//   reset    in   1     asynchronous, active-high reset
//   start    in   1     request pulse, accepted in IDLE or DONE only
//   funct3   in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                       100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a     in   XLEN  rs1 (multiplicand / dividend)
//   op_b     in   XLEN  rs2 (multiplier / divisor)
//   busy     out  1     high while iterating (CALC)
//   done     out  1     one-cycle pulse, result valid
//   result   out  XLEN  registered result
//
// Configuration
//   EARLY_OUT_EN  when defined, divide-by-zero, signed divide overflow and
//                 multiply by zero skip CALC and complete one edge after
//                 the start edge.
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;          // negate product / quotient
    logic            nega_q, nega_d;        // dividend was negative (remainder sign)
    logic            special_q, special_d;  // boundary case, result precomputed
    logic [XLEN-1:0] special_res_q, special_res_d;
    logic [XLEN-1:0] acc_q, acc_d;          // product high half / partial remainder
    logic [XLEN-1:0] sh_q, sh_d;            // multiplier (shifting out) / dividend -> quotient
    logic [XLEN-1:0] b_q, b_d;              // multiplicand / divisor magnitude
    logic [XLEN-1:0] result_q, result_d;

    // ---------------- Operand decode at acceptance ----------------
    logic            is_div_in, a_signed_in, b_signed_in;
    logic            neg_a_in, neg_b_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in;
    logic            special_in;
    logic [XLEN-1:0] special_res_in;

    always_comb begin
        is_div_in = funct3[2];
        // Divides: DIV/REM signed. Multiplies: MULHU fully unsigned,
        // MULHSU signed a only. MUL low half is sign-agnostic.
        a_signed_in = is_div_in ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed_in = is_div_in ? ~funct3[0] : ~funct3[1];
        neg_a_in    = a_signed_in & op_a[XLEN-1];
        neg_b_in    = b_signed_in & op_b[XLEN-1];
        mag_a_in    = neg_a_in ? -op_a : op_a;
        mag_b_in    = neg_b_in ? -op_b : op_b;

        special_in     = 1'b0;
        special_res_in = '0;
        if (is_div_in) begin
            if (op_b == '0) begin
                special_in     = 1'b1;
                special_res_in = funct3[1] ? op_a : '1;
            end else if (!funct3[0] && op_a == MIN_NEG && op_b == '1) begin
                special_in     = 1'b1;
                special_res_in = funct3[1] ? '0 : op_a;
            end
        end else if (op_a == '0 || op_b == '0) begin
            special_in     = 1'b1;
            special_res_in = '0;
        end
    end

    // ---------------- One iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   acc_n, sh_n;

    always_comb begin
        // Multiply: add multiplicand when the low multiplier bit is set,
        // then shift the 2*XLEN {acc, sh} pair right by one.
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
        // Divide: bring in the next dividend bit; subtract if it fits.
        // The top bit of the difference is the borrow.
        div_shift = {acc_q, sh_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = ~div_diff[XLEN];
        if (f3_q[2]) begin
            acc_n = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            sh_n  = {sh_q[XLEN-2:0], div_ge};
        end else begin
            acc_n = mul_sum[XLEN:1];
            sh_n  = {mul_sum[0], sh_q[XLEN-1:1]};
        end
    end

    // ---------------- Final result from the last step ----------------
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_raw = {acc_n, sh_n};
        prod_fix = neg_q ? -prod_raw : prod_raw;
        if (special_q) begin
            final_res = special_res_q;
        end else if (f3_q[2]) begin
            if (f3_q[1]) final_res = nega_q ? -acc_n : acc_n;   // REM / REMU
            else         final_res = neg_q  ? -sh_n  : sh_n;    // DIV / DIVU
        end else if (f3_q[1:0] == 2'b00) begin
            final_res = prod_fix[XLEN-1:0];
        end else begin
            final_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // ---------------- Control ----------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        f3_d          = f3_q;
        neg_d         = neg_q;
        nega_d        = nega_q;
        special_d     = special_q;
        special_res_d = special_res_q;
        acc_d         = acc_q;
        sh_d          = sh_q;
        b_d           = b_q;
        result_d      = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    f3_d          = funct3;
                    neg_d         = neg_a_in ^ neg_b_in;
                    nega_d        = neg_a_in;
                    special_d     = special_in;
                    special_res_d = special_res_in;
                    acc_d         = '0;
                    cnt_d         = '0;
                    sh_d          = is_div_in ? mag_a_in : mag_b_in;
                    b_d           = is_div_in ? mag_b_in : mag_a_in;
                    state_d       = S_CALC;
`ifdef EARLY_OUT_EN
                    if (special_in) begin
                        state_d  = S_DONE;
                        result_d = special_res_in;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = acc_n;
                sh_d  = sh_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            f3_q          <= '0;
            neg_q         <= 1'b0;
            nega_q        <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            acc_q         <= '0;
            sh_q          <= '0;
            b_q           <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            f3_q          <= f3_d;
            neg_q         <= neg_d;
            nega_q        <= nega_d;
            special_q     <= special_d;
            special_res_q <= special_res_d;
            acc_q         <= acc_d;
            sh_q          <= sh_d;
            b_q           <= b_d;
            result_q      <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed vectors with hand-computed results for mul_div_unit, including
//   latency, busy duration, ignored start, back-to-back start and reset abort.
//   Latency counts the edge that samples start as edge 1.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int XLEN = 64;
    localparam int LAT_FULL = 65;
`ifdef EARLY_OUT_EN
    localparam int LAT_SPEC  = 1;
    localparam int BUSY_SPEC = 0;
`else
    localparam int LAT_SPEC  = 65;
    localparam int BUSY_SPEC = 64;
`endif

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request so the next rising edge samples it, then scramble the
    // operand inputs to show the unit works from its latched copies.
    task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = {$urandom, $urandom};
        op_b   = {$urandom, $urandom};
    endtask

    // Most recent rising edge is edge 1. Returns the edge count at which done
    // is seen (-1 on timeout) and the number of cycles busy was high before it.
    task automatic wait_done(output int edges, output int busy_cycles);
        int e;
        int bc;
        e  = 1;
        bc = 0;
        @(negedge clk);
        while (!done && e < 200) begin
            if (busy) bc++;
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        edges       = done ? e : -1;
        busy_cycles = bc;
    endtask

    task automatic op(input string tag, input logic [2:0] f, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                      input int exp_busy);
        int e;
        int bc;
        issue(f, a, b);
        wait_done(e, bc);
        $display("op %s f3=%0d a=%h b=%h -> result=%h edges=%0d busy=%0d",
                 tag, f, a, b, result, e, bc);
        check({tag, " result"}, result, exp);
        check({tag, " latency"}, 64'(e), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(bc), 64'(exp_busy));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done single pulse"}, {63'b0, done}, 64'd0);
        check({tag, " result held"}, result, exp);
    endtask

    initial begin
        int e;
        int bc;
        int seen;

        reset  = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset done", {63'b0, done}, 64'd0);
        check("reset result", result, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        op("MUL -3*7",   F_MUL,    -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, LAT_FULL, 64);
        op("MUL 6*7",    F_MUL,    64'd6, 64'd7, 64'd42, LAT_FULL, 64);
        op("MULHU",      F_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, LAT_FULL, 64);
        op("MULH",       F_MULH,   64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_FULL, 64);
        op("MULHSU",     F_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, LAT_FULL, 64);
        op("DIV -20/3",  F_DIV,    -64'sd20, 64'd3, -64'sd6, LAT_FULL, 64);
        op("REM -20/3",  F_REM,    -64'sd20, 64'd3, -64'sd2, LAT_FULL, 64);
        op("DIVU 100/7", F_DIVU,   64'd100, 64'd7, 64'd14, LAT_FULL, 64);
        op("REMU 100/7", F_REMU,   64'd100, 64'd7, 64'd2, LAT_FULL, 64);
        op("DIVU 5/0",   F_DIVU,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SPEC, BUSY_SPEC);
        op("DIV -7/0",   F_DIV,    -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SPEC, BUSY_SPEC);
        op("REM 5/0",    F_REM,    64'd5, 64'd0, 64'd5, LAT_SPEC, BUSY_SPEC);
        op("REMU -7/0",  F_REMU,   -64'sd7, 64'd0, -64'sd7, LAT_SPEC, BUSY_SPEC);
        op("DIV ovf",    F_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, LAT_SPEC, BUSY_SPEC);
        op("REM ovf",    F_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, LAT_SPEC, BUSY_SPEC);
        op("MUL 0*5",    F_MUL,    64'd0, 64'd5, 64'd0, LAT_SPEC, BUSY_SPEC);

        // Start pulsed while busy: edges 1..5 elapse, edge 6 sees the pulse.
        issue(F_DIVU, 64'd100, 64'd7);
        repeat (4) @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = F_MUL;
        op_a   = 64'd3;
        op_b   = 64'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(e, bc);
        $display("op ignored-start DIVU 100/7 -> result=%h edges=%0d", result, e);
        check("ignored start result", result, 64'd14);
        check("ignored start latency", 64'(e), 64'd60);

        // Back-to-back: start issued in the DONE cycle.
        issue(F_MUL, 64'd6, 64'd7);
        check("b2b busy rises", {63'b0, busy}, 64'd1);
        check("b2b done falls", {63'b0, done}, 64'd0);
        wait_done(e, bc);
        $display("op back-to-back MUL 6*7 -> result=%h edges=%0d", result, e);
        check("b2b result", result, 64'd42);
        check("b2b latency", 64'(e), 64'(LAT_FULL));

        // Reset mid-CALC aborts immediately and no done pulse follows.
        @(negedge clk);
        issue(F_DIVU, 64'd100, 64'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", {63'b0, busy}, 64'd0);
        check("abort done", {63'b0, done}, 64'd0);
        check("abort result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        $display("op reset-abort DIVU 100/7 -> activity cycles after reset=%0d", seen);
        check("abort no done", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
